johnson_phase_decoder: RTL and testbench



---
 rtl/johnson_phase_decoder.sv | 142 ++++++++++++++
 tb/tb_johnson_phase_decoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/johnson_phase_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : johnson_phase_decoder                                         |
// | Description : Decodes a twisted-ring (Johnson) code into one-hot and binary |
// |               phase, tracks continuity, counts revolutions, flags errors.   |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module johnson_phase_decoder #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 3,
    parameter int REV_W = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     jc,
    input  logic                 ack_err,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   phase_oh,
    output logic [IDX_W-1:0]     phase_idx,
    output logic [REV_W-1:0]     rev_count,
    output logic                 illegal,
    output logic                 seq_err,
    output logic                 err_sticky
);

    localparam int c_P = 2 * WIDTH;

    typedef enum logic [0:0] {
        S_SYNC  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    state_t             r_state,      w_state_nxt;
    logic               r_out_valid,  w_out_valid_nxt;
    logic [c_P-1:0]     r_phase_oh,   w_phase_oh_nxt;
    logic [IDX_W-1:0]   r_phase_idx,  w_phase_idx_nxt;
    logic [REV_W-1:0]   r_rev_count,  w_rev_count_nxt;
    logic               r_illegal,    w_illegal_nxt;
    logic               r_seq_err,    w_seq_err_nxt;
    logic               r_err_sticky, w_err_sticky_nxt;

    logic               w_legal;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_idx_inc;

    // Code for phase k: k ones from bit 0 for k<=WIDTH, else ones above (k-WIDTH) zeros.
    function automatic logic [WIDTH-1:0] f_code(input int k);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int b = 0; b < WIDTH; b++) begin
            if (k <= WIDTH) v[b] = (b < k);
            else            v[b] = (b >= k - WIDTH);
        end
        return v;
    endfunction

    always_comb begin
        w_legal = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < c_P; k++) begin
            if (jc == f_code(k)) begin
                w_legal = 1'b1;
                w_idx   = IDX_W'(k);
            end
        end
    end

    // phase_idx always mirrors the last accepted phase, so it serves as prev_idx.
    assign w_idx_inc = (r_phase_idx == IDX_W'(c_P - 1)) ? '0 : r_phase_idx + IDX_W'(1);

    always_comb begin
        w_state_nxt      = r_state;
        w_out_valid_nxt  = 1'b0;
        w_phase_oh_nxt   = r_phase_oh;
        w_phase_idx_nxt  = r_phase_idx;
        w_rev_count_nxt  = r_rev_count;
        w_illegal_nxt    = 1'b0;
        w_seq_err_nxt    = 1'b0;
        w_err_sticky_nxt = r_err_sticky & ~ack_err;

        if (in_valid) begin
            if (!w_legal) begin
                w_illegal_nxt  = 1'b1;
                w_phase_oh_nxt = '0;
                w_state_nxt    = S_SYNC;
            end else begin
                w_out_valid_nxt         = 1'b1;
                w_phase_oh_nxt          = '0;
                w_phase_oh_nxt[w_idx]   = 1'b1;
                w_phase_idx_nxt         = w_idx;
                w_state_nxt             = S_TRACK;
                if (r_state == S_TRACK) begin
                    if (w_idx == r_phase_idx) begin
                        w_phase_idx_nxt = r_phase_idx;
                    end else if (w_idx == w_idx_inc) begin
                        if (r_phase_idx == IDX_W'(c_P - 1))
                            w_rev_count_nxt = r_rev_count + REV_W'(1);
                    end else begin
                        w_seq_err_nxt = 1'b1;
                    end
                end
            end
        end

        // A new error outranks an acknowledge on the same cycle.
        if (w_illegal_nxt || w_seq_err_nxt)
            w_err_sticky_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state      <= S_SYNC;
            r_out_valid  <= 1'b0;
            r_phase_oh   <= '0;
            r_phase_idx  <= '0;
            r_rev_count  <= '0;
            r_illegal    <= 1'b0;
            r_seq_err    <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_phase_oh   <= w_phase_oh_nxt;
            r_phase_idx  <= w_phase_idx_nxt;
            r_rev_count  <= w_rev_count_nxt;
            r_illegal    <= w_illegal_nxt;
            r_seq_err    <= w_seq_err_nxt;
            r_err_sticky <= w_err_sticky_nxt;
        end
    end

    assign out_valid  = r_out_valid;
    assign phase_oh   = r_phase_oh;
    assign phase_idx  = r_phase_idx;
    assign rev_count  = r_rev_count;
    assign illegal    = r_illegal;
    assign seq_err    = r_seq_err;
    assign err_sticky = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_johnson_phase_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_johnson_phase_decoder                                      |
// | Description : Directed self-checking bench for johnson_phase_decoder.       |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_johnson_phase_decoder;

    logic       clk = 1'b0;
    logic       clr;
    logic       in_valid;
    logic [3:0] jc;
    logic       ack_err;

    logic       out_valid,  out_valid2;
    logic [7:0] phase_oh,   phase_oh2;
    logic [2:0] phase_idx,  phase_idx2;
    logic [7:0] rev_count;
    logic [1:0] rev_count2;
    logic       illegal,    illegal2;
    logic       seq_err,    seq_err2;
    logic       err_sticky, err_sticky2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                              4'b1111, 4'b1110, 4'b1100, 4'b1000};

    johnson_phase_decoder #(.WIDTH(4), .IDX_W(3), .REV_W(8)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .jc(jc), .ack_err(ack_err),
        .out_valid(out_valid), .phase_oh(phase_oh), .phase_idx(phase_idx),
        .rev_count(rev_count), .illegal(illegal), .seq_err(seq_err),
        .err_sticky(err_sticky)
    );

    // Narrow revolution counter exercises the wrap without hundreds of cycles.
    johnson_phase_decoder #(.WIDTH(4), .IDX_W(3), .REV_W(2)) dut2 (
        .clk(clk), .clr(clr), .in_valid(in_valid), .jc(jc), .ack_err(ack_err),
        .out_valid(out_valid2), .phase_oh(phase_oh2), .phase_idx(phase_idx2),
        .rev_count(rev_count2), .illegal(illegal2), .seq_err(seq_err2),
        .err_sticky(err_sticky2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic c, input logic v, input logic [3:0] code, input logic ack);
        clr      = c;
        in_valid = v;
        jc       = code;
        ack_err  = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] idx,
                           input logic [7:0] oh, input logic ill, input logic seq,
                           input logic sticky);
        chk({tag, ".valid"},  32'(out_valid),  32'(v));
        chk({tag, ".idx"},    32'(phase_idx),  32'(idx));
        chk({tag, ".oh"},     32'(phase_oh),   32'(oh));
        chk({tag, ".ill"},    32'(illegal),    32'(ill));
        chk({tag, ".seq"},    32'(seq_err),    32'(seq));
        chk({tag, ".sticky"}, 32'(err_sticky), 32'(sticky));
    endtask

    initial begin
        // Reset held two cycles with a legal code present
        apply(1'b1, 1'b1, 4'b0011, 1'b0);
        chk_out("rst1", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 4'b0011, 1'b0);
        chk_out("rst2", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rst2.rev", 32'(rev_count), 32'd0);
        apply(1'b0, 1'b1, 4'b0011, 1'b0);
        chk_out("first", 1'b1, 3'd2, 8'h04, 1'b0, 1'b0, 1'b0);

        // Two full revolutions from 0000
        apply(1'b1, 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 17; i++) begin
            apply(1'b0, 1'b1, codes[i % 8], 1'b0);
            chk_out($sformatf("rev%0d", i), 1'b1, 3'(i % 8), 8'(1 << (i % 8)),
                    1'b0, 1'b0, 1'b0);
            chk($sformatf("rev%0d.cnt", i), 32'(rev_count),
                32'((i >= 8 ? 1 : 0) + (i >= 16 ? 1 : 0)));
        end
        chk("rev.cnt2", 32'(rev_count2), 32'd2);

        // Hold and gaps
        apply(1'b0, 1'b1, 4'b0001, 1'b0);
        apply(1'b0, 1'b1, 4'b0011, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 4'b0111, 1'b0);
            chk_out($sformatf("hold%0d", i), 1'b1, 3'd3, 8'h08, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b0, 4'b1010, 1'b0);
            chk_out($sformatf("gap%0d", i), 1'b0, 3'd3, 8'h08, 1'b0, 1'b0, 1'b0);
        end
        apply(1'b0, 1'b1, 4'b1111, 1'b0);
        chk_out("preset_ok", 1'b1, 3'd4, 8'h10, 1'b0, 1'b0, 1'b0);

        // Walk on to idx 1 (third wrap), then skip forward and step back
        apply(1'b0, 1'b1, 4'b1110, 1'b0);
        apply(1'b0, 1'b1, 4'b1100, 1'b0);
        apply(1'b0, 1'b1, 4'b1000, 1'b0);
        apply(1'b0, 1'b1, 4'b0000, 1'b0);
        apply(1'b0, 1'b1, 4'b0001, 1'b0);
        chk_out("pre_skip", 1'b1, 3'd1, 8'h02, 1'b0, 1'b0, 1'b0);
        chk("pre_skip.rev", 32'(rev_count), 32'd3);
        apply(1'b0, 1'b1, 4'b0111, 1'b0);
        chk_out("skip", 1'b1, 3'd3, 8'h08, 1'b0, 1'b1, 1'b1);
        apply(1'b0, 1'b1, 4'b0011, 1'b0);
        chk_out("back", 1'b1, 3'd2, 8'h04, 1'b0, 1'b1, 1'b1);
        chk("back.rev", 32'(rev_count), 32'd3);
        apply(1'b0, 1'b0, 4'b0011, 1'b1);
        chk_out("ack", 1'b0, 3'd2, 8'h04, 1'b0, 1'b0, 1'b0);

        // Illegal code and silent resync
        apply(1'b0, 1'b1, 4'b0011, 1'b0);
        chk_out("pre_ill", 1'b1, 3'd2, 8'h04, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 4'b0101, 1'b0);
        chk_out("ill", 1'b0, 3'd2, 8'h00, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 4'b1100, 1'b0);
        chk_out("resync", 1'b1, 3'd6, 8'h40, 1'b0, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 4'b1100, 1'b1);
        chk("ack2.sticky", 32'(err_sticky), 32'd0);

        // Fourth wrap: narrow counter rolls 3 -> 0
        apply(1'b0, 1'b1, 4'b1000, 1'b0);
        chk("rev3.narrow", 32'(rev_count2), 32'd3);
        apply(1'b0, 1'b1, 4'b0000, 1'b0);
        chk_out("wrap4", 1'b1, 3'd0, 8'h01, 1'b0, 1'b0, 1'b0);
        chk("wrap4.rev", 32'(rev_count), 32'd4);
        chk("wrap4.narrow", 32'(rev_count2), 32'd0);

        // Illegal with ack on the same cycle: set wins
        apply(1'b0, 1'b1, 4'b1010, 1'b1);
        chk_out("collide", 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 4'b1010, 1'b1);
        chk("collide.ack", 32'(err_sticky), 32'd0);

        // Preset from idx 1 in TRACK is a sequence error
        apply(1'b0, 1'b1, 4'b0001, 1'b0);
        chk_out("sync1", 1'b1, 3'd1, 8'h02, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 4'b1111, 1'b0);
        chk_out("preset_bad", 1'b1, 3'd4, 8'h10, 1'b0, 1'b1, 1'b1);

        // Mid-operation clear, then preset accepted silently
        apply(1'b1, 1'b1, 4'b1111, 1'b0);
        chk_out("midclr", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("midclr.rev", 32'(rev_count), 32'd0);
        apply(1'b0, 1'b1, 4'b1111, 1'b0);
        chk_out("post_clr", 1'b1, 3'd4, 8'h10, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
